// File: rtl/hazard_unit_pkg.sv
// hazard_defs: forwarding encodings, shadow-stage records and the register-match helper
package hazard_defs;
  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_RESULTW = 2'd1;
  localparam logic [1:0] FWD_ALUOUTM = 2'd2;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       rw;
    logic       mr;
  } e_stage_t;
  typedef struct packed {
    logic [4:0] wr;
    logic       rw;
    logic       mr;
  } m_stage_t;
  typedef struct packed {
    logic [4:0] wr;
    logic       rw;
  } w_stage_t;
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic en);
    return en && src != REG_ZERO && src == dst;
  endfunction
endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: E/M/W copies of destination info, with bubble insertion into E
module hazard_shadow_pipe
  import hazard_defs::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  e_stage_t d_i,
  output e_stage_t e_o,
  output m_stage_t m_o,
  output w_stage_t w_o
);
  e_stage_t e_q;
  m_stage_t m_q;
  w_stage_t w_q;
  // advance the shadow pipeline; a flush turns the incoming E entry into a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= flush_i ? '0 : d_i;
      m_q <= '{wr: e_q.wr, rw: e_q.rw, mr: e_q.mr};
      w_q <= '{wr: m_q.wr, rw: m_q.rw};
    end
  end
  assign e_o = e_q;
  assign m_o = m_q;
  assign w_o = w_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load/branch stalls and a saturating stall counter
module hazard_unit
  import hazard_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount
);
  e_stage_t d, e;
  m_stage_t m;
  w_stage_t w;
  logic lwstall, branchstall, stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign d = '{rs: RsD, rt: RtD, wr: RegDstD ? RdD : RtD, rw: RegWriteD, mr: MemtoRegD};
  hazard_shadow_pipe u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(FlushE),
    .d_i    (d),
    .e_o    (e),
    .m_o    (m),
    .w_o    (w)
  );
  // hazard detection and forwarding; everything is gated off while in reset.
  // A load in M carries its address on ALUOutM, so it is never forwarded to decode.
  always_comb begin
    lwstall     = hit(RsD, e.wr, e.mr) || hit(RtD, e.wr, e.mr);
    branchstall = BranchD && (hit(RsD, e.wr, e.rw) || hit(RtD, e.wr, e.rw) ||
                              hit(RsD, m.wr, m.mr) || hit(RtD, m.wr, m.mr));
    stall       = rst_n && (lwstall || branchstall);
    ForwardAE   = !rst_n ? FWD_RF : hit(e.rs, m.wr, m.rw) ? FWD_ALUOUTM :
                  hit(e.rs, w.wr, w.rw) ? FWD_RESULTW : FWD_RF;
    ForwardBE   = !rst_n ? FWD_RF : hit(e.rt, m.wr, m.rw) ? FWD_ALUOUTM :
                  hit(e.rt, w.wr, w.rw) ? FWD_RESULTW : FWD_RF;
    ForwardAD   = rst_n && hit(RsD, m.wr, m.rw && !m.mr);
    ForwardBD   = rst_n && hit(RtD, m.wr, m.rw && !m.mr);
    StallF      = stall;
    StallD      = stall;
    FlushE      = stall;
    cnt_d       = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    StallCount  = rst_n ? cnt_q : '0;
  end
  // stall-cycle counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule
